// File: rtl/spi_rx.sv
// SPI peripheral (slave) receiver/transmitter.
// The cs, sclk and mosi pins are oversampled in the clk domain.
// Each completed MOSI word is presented on rx_dout together with a one-cycle rx_vld pulse.
// Words queued through a one-entry tx buffer are shifted out on MISO, MSB first.
module spi_rx #(
    parameter int mode  = 0,
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [width-1:0] tx_din,
    input  logic             tx_vld,
    output logic             tx_rdy,
    output logic [width-1:0] rx_dout,
    output logic             rx_vld,
    output logic             tx_unf
);

    localparam logic CPOL = ((mode & 2) != 0);
    localparam logic CPHA = ((mode & 1) != 0);
    localparam int   CW   = $clog2(width);
    localparam logic [CW-1:0] LAST = CW'(width - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Synchronizers: two flops per pin, plus a third sclk flop for edge detection.
    logic cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d;
    logic sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_s3_q, sclk_s3_d;
    logic mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;

    // Control state.
    state_t          state_q, state_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic            loaded_q, loaded_d;
    logic            buf_full_q, buf_full_d;
    logic [1:0]      warm_q, warm_d;
    logic            armed_q, armed_d;

    // Registered outputs.
    logic             miso_q, miso_d;
    logic             miso_oe_q, miso_oe_d;
    logic [width-1:0] rx_dout_q, rx_dout_d;
    logic             rx_vld_q, rx_vld_d;
    logic             tx_unf_q, tx_unf_d;

    // Datapath (no reset needed: always initialised before use).
    logic [width-1:0] rx_sr_q, rx_sr_d;
    logic [width-1:0] tx_sr_q, tx_sr_d;
    logic [width-1:0] buf_q, buf_d;

    logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic accept, load;

    assign sclk_edge   = sclk_s2_q ^ sclk_s3_q;
    assign lead_edge   = sclk_edge && (sclk_s2_q != CPOL);
    assign trail_edge  = sclk_edge && (sclk_s2_q == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    assign tx_rdy  = !buf_full_q;
    assign accept  = tx_vld && !buf_full_q;

    assign miso    = miso_q;
    assign miso_oe = miso_oe_q;
    assign rx_dout = rx_dout_q;
    assign rx_vld  = rx_vld_q;
    assign tx_unf  = tx_unf_q;

    // Next-state logic for the synchronizers, frame FSM, shift registers and tx buffer.
    always_comb begin
        cs_s1_d    = cs;
        cs_s2_d    = cs_s1_q;
        sclk_s1_d  = sclk;
        sclk_s2_d  = sclk_s1_q;
        sclk_s3_d  = sclk_s2_q;
        mosi_s1_d  = mosi;
        mosi_s2_d  = mosi_s1_q;

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        loaded_d   = loaded_q;
        buf_full_d = buf_full_q;
        buf_d      = buf_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        rx_dout_d  = rx_dout_q;
        rx_vld_d   = 1'b0;
        tx_unf_d   = 1'b0;
        load       = 1'b0;

        // The synchronizer holds reset values for two cycles after reset.
        // Only trust cs_s2 once real pin data has reached it.
        // A frame may only start after cs has genuinely been seen high.
        warm_d  = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
        armed_d = armed_q | ((warm_q == 2'd2) && cs_s2_q);

        case (state_q)
            ST_IDLE: begin
                if (armed_q && !cs_s2_q) begin
                    state_d   = ST_ACTIVE;
                    load      = 1'b1;
                    loaded_d  = 1'b1;
                    bit_cnt_d = '0;
                    rx_sr_d   = '0;
                end
            end
            ST_ACTIVE: begin
                if (cs_s2_q) begin
                    // Frame ended, possibly mid-word: drop partial data, keep the buffer.
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    loaded_d  = 1'b0;
                    rx_sr_d   = '0;
                    tx_sr_d   = '0;
                end else if (sample_edge) begin
                    rx_sr_d = {rx_sr_q[width-2:0], mosi_s2_q};
                    if (bit_cnt_q == LAST) begin
                        rx_dout_d = rx_sr_d;
                        rx_vld_d  = 1'b1;
                        bit_cnt_d = '0;
                        loaded_d  = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end else if (shift_edge) begin
                    if (bit_cnt_q == '0) begin
                        if (!loaded_q) begin
                            load     = 1'b1;
                            loaded_d = 1'b1;
                        end
                    end else begin
                        tx_sr_d = {tx_sr_q[width-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A load drains the buffer first; an accept in the same cycle refills it.
        if (load) begin
            if (buf_full_q) begin
                tx_sr_d = buf_q;
            end else begin
                tx_sr_d  = '0;
                tx_unf_d = 1'b1;
            end
            buf_full_d = 1'b0;
        end
        if (accept) begin
            buf_full_d = 1'b1;
            buf_d      = tx_din;
        end

        miso_oe_d = (state_d == ST_ACTIVE);
        miso_d    = (state_d == ST_ACTIVE) ? tx_sr_d[width-1] : 1'b0;
    end

    // Control and output registers, with synchronous reset to idle levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_s1_q    <= 1'b1;
            cs_s2_q    <= 1'b1;
            sclk_s1_q  <= CPOL;
            sclk_s2_q  <= CPOL;
            sclk_s3_q  <= CPOL;
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            loaded_q   <= 1'b0;
            buf_full_q <= 1'b0;
            warm_q     <= 2'd0;
            armed_q    <= 1'b0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            rx_dout_q  <= '0;
            rx_vld_q   <= 1'b0;
            tx_unf_q   <= 1'b0;
        end else begin
            cs_s1_q    <= cs_s1_d;
            cs_s2_q    <= cs_s2_d;
            sclk_s1_q  <= sclk_s1_d;
            sclk_s2_q  <= sclk_s2_d;
            sclk_s3_q  <= sclk_s3_d;
            mosi_s1_q  <= mosi_s1_d;
            mosi_s2_q  <= mosi_s2_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            loaded_q   <= loaded_d;
            buf_full_q <= buf_full_d;
            warm_q     <= warm_d;
            armed_q    <= armed_d;
            miso_q     <= miso_d;
            miso_oe_q  <= miso_oe_d;
            rx_dout_q  <= rx_dout_d;
            rx_vld_q   <= rx_vld_d;
            tx_unf_q   <= tx_unf_d;
        end
    end

    // Shift registers and buffer word; these are qualified by control state, so they have no reset.
    always_ff @(posedge clk) begin
        rx_sr_q <= rx_sr_d;
        tx_sr_q <= tx_sr_d;
        buf_q   <= buf_d;
    end

endmodule

// File: tb/tb_spi_rx.sv
// Directed bench for spi_rx: one instance per SPI mode, driven by a behavioural controller.
module tb_spi_rx;

    localparam int H = 16;   // sclk half period in clk cycles (sclk = clk/32)

    logic       clk = 1'b0;
    logic       rst;
    logic       cs_p     [4];
    logic       sclk_p   [4];
    logic       mosi_p   [4];
    logic       tx_vld_p [4];
    logic [7:0] tx_din_p [4];
    logic       miso_w   [4];
    logic       miso_oe_w[4];
    logic       tx_rdy_w [4];
    logic [7:0] rx_dout_w[4];
    logic       rx_vld_w [4];
    logic       tx_unf_w [4];

    int rx_cnt [4] = '{default: 0};
    int unf_cnt[4] = '{default: 0};
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_rx #(.mode(g), .width(8)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .cs      (cs_p[g]),
            .sclk    (sclk_p[g]),
            .mosi    (mosi_p[g]),
            .miso    (miso_w[g]),
            .miso_oe (miso_oe_w[g]),
            .tx_din  (tx_din_p[g]),
            .tx_vld  (tx_vld_p[g]),
            .tx_rdy  (tx_rdy_w[g]),
            .rx_dout (rx_dout_w[g]),
            .rx_vld  (rx_vld_w[g]),
            .tx_unf  (tx_unf_w[g])
        );
    end

    // Count rx_vld and tx_unf pulses per instance.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rx_vld_w[i]) rx_cnt[i] <= rx_cnt[i] + 1;
            if (tx_unf_w[i]) unf_cnt[i] <= unf_cnt[i] + 1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int m, input logic [7:0] v);
        int t;
        t = 0;
        while (!tx_rdy_w[m] && t < 200) begin
            wclk(1);
            t++;
        end
        chk($sformatf("m%0d_push_rdy", m), tx_rdy_w[m], 1);
        tx_din_p[m] = v;
        tx_vld_p[m] = 1'b1;
        wclk(1);
        tx_vld_p[m] = 1'b0;
    endtask

    task automatic cs_low(input int m);
        cs_p[m] = 1'b0;
        wclk(4);
    endtask

    task automatic cs_high(input int m);
        wclk(H);
        cs_p[m] = 1'b1;
        wclk(8);
    endtask

    // Controller side of one word (or nb leading bits of it), MSB first.
    task automatic xfer(input int m, input logic [7:0] din, input int nb, output logic [7:0] dout);
        bit cpol, cpha;
        int i;
        cpol = ((m & 2) != 0);
        cpha = ((m & 1) != 0);
        dout = 8'h00;
        for (int k = 0; k < nb; k++) begin
            i = 7 - k;
            if (!cpha) begin
                mosi_p[m] = din[i];
                wclk(H);
                dout[i] = miso_w[m];
                sclk_p[m] = ~cpol;
                wclk(H);
                sclk_p[m] = cpol;
            end else begin
                wclk(H);
                sclk_p[m] = ~cpol;
                mosi_p[m] = din[i];
                wclk(H);
                dout[i] = miso_w[m];
                sclk_p[m] = cpol;
            end
        end
    endtask

    task automatic chk_reset_outs(input string tag, input int m);
        chk({tag, "_miso"},    miso_w[m],    0);
        chk({tag, "_oe"},      miso_oe_w[m], 0);
        chk({tag, "_tx_rdy"},  tx_rdy_w[m],  1);
        chk({tag, "_rx_dout"}, rx_dout_w[m], 0);
        chk({tag, "_rx_vld"},  rx_vld_w[m],  0);
        chk({tag, "_tx_unf"},  tx_unf_w[m],  0);
    endtask

    initial begin
        logic [7:0] got;
        int rb, ub;
        int ml[3] = '{3, 1, 2};

        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cs_p[i]     = 1'b1;
            sclk_p[i]   = (i >= 2);
            mosi_p[i]   = 1'b0;
            tx_vld_p[i] = 1'b0;
            tx_din_p[i] = 8'h00;
        end
        wclk(5);
        chk_reset_outs("rst0", 0);
        chk_reset_outs("rst3", 3);
        rst = 1'b0;
        wclk(5);

        // Mode 0: 0xA5 in, 0x3C out.
        push(0, 8'h3C);
        chk("m0_tx_rdy_full", tx_rdy_w[0], 0);
        rb = rx_cnt[0];
        cs_low(0);
        chk("m0_tx_rdy_after_cs", tx_rdy_w[0], 1);
        chk("m0_oe_active", miso_oe_w[0], 1);
        xfer(0, 8'hA5, 8, got);
        cs_high(0);
        chk("m0_rx_dout", rx_dout_w[0], 8'hA5);
        chk("m0_rx_pulses", rx_cnt[0] - rb, 1);
        chk("m0_miso_word", got, 8'h3C);
        chk("m0_oe_idle", miso_oe_w[0], 0);

        // Modes 3, 1, 2: 0x5A in, 0xC3 out.
        foreach (ml[j]) begin
            push(ml[j], 8'hC3);
            rb = rx_cnt[ml[j]];
            cs_low(ml[j]);
            xfer(ml[j], 8'h5A, 8, got);
            cs_high(ml[j]);
            chk($sformatf("m%0d_rx_dout", ml[j]), rx_dout_w[ml[j]], 8'h5A);
            chk($sformatf("m%0d_rx_pulses", ml[j]), rx_cnt[ml[j]] - rb, 1);
            chk($sformatf("m%0d_miso_word", ml[j]), got, 8'hC3);
        end

        // Mode 0: three words in one frame, buffer refilled whenever it empties.
        push(0, 8'h11);
        rb = rx_cnt[0];
        ub = unf_cnt[0];
        cs_low(0);
        push(0, 8'h22);
        xfer(0, 8'h01, 8, got);
        chk("bb_rx1", rx_dout_w[0], 8'h01);
        chk("bb_tx1", got, 8'h11);
        push(0, 8'h33);
        xfer(0, 8'h80, 8, got);
        chk("bb_rx2", rx_dout_w[0], 8'h80);
        chk("bb_tx2", got, 8'h22);
        push(0, 8'h44);
        xfer(0, 8'hFF, 8, got);
        chk("bb_rx3", rx_dout_w[0], 8'hFF);
        chk("bb_tx3", got, 8'h33);
        cs_high(0);
        chk("bb_rx_pulses", rx_cnt[0] - rb, 3);
        chk("bb_unf", unf_cnt[0] - ub, 0);

        // Mode 1: empty buffer at cs fall.
        chk("unf_pre_rdy", tx_rdy_w[1], 1);
        rb = rx_cnt[1];
        ub = unf_cnt[1];
        cs_low(1);
        xfer(1, 8'h96, 8, got);
        cs_high(1);
        chk("unf_pulses", unf_cnt[1] - ub, 1);
        chk("unf_miso_word", got, 8'h00);
        chk("unf_rx_dout", rx_dout_w[1], 8'h96);
        chk("unf_rx_pulses", rx_cnt[1] - rb, 1);

        // Mode 0: cs aborts after 5 bits, then a clean frame.
        rb = rx_cnt[0];
        cs_low(0);
        xfer(0, 8'hF0, 5, got);
        cs_high(0);
        chk("abort_rx_pulses", rx_cnt[0] - rb, 0);
        chk("abort_oe", miso_oe_w[0], 0);
        chk("abort_miso", miso_w[0], 0);
        chk("abort_rx_dout_kept", rx_dout_w[0], 8'hFF);
        rb = rx_cnt[0];
        cs_low(0);
        xfer(0, 8'h0F, 8, got);
        cs_high(0);
        chk("after_abort_rx_dout", rx_dout_w[0], 8'h0F);
        chk("after_abort_pulses", rx_cnt[0] - rb, 1);

        // Mode 0: reset after 4 bits with cs held low.
        cs_low(0);
        xfer(0, 8'hAA, 4, got);
        rst = 1'b1;
        wclk(2);
        chk_reset_outs("midrst", 0);
        rst = 1'b0;
        wclk(6);
        chk("midrst_oe_wait", miso_oe_w[0], 0);
        rb = rx_cnt[0];
        xfer(0, 8'h77, 8, got);
        wclk(6);
        chk("midrst_no_rx", rx_cnt[0] - rb, 0);
        chk("midrst_oe_still", miso_oe_w[0], 0);
        chk("midrst_rx_dout", rx_dout_w[0], 8'h00);
        cs_high(0);
        cs_low(0);
        chk("midrst_oe_rearm", miso_oe_w[0], 1);
        xfer(0, 8'h5C, 8, got);
        cs_high(0);
        chk("midrst_new_rx", rx_dout_w[0], 8'h5C);
        chk("midrst_new_pulses", rx_cnt[0] - rb, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
